// File: rtl/chimp_sequencer.sv
// rtl/chimp_sequencer.sv - chimp memory test game-control FSM
// Counter-based level/lives/expect tracking with registered outputs.
module chimp_sequencer #(
  parameter int MAX_LEVEL   = 31,
  parameter int START_LEVEL = 4,
  parameter int NUM_LIVES   = 3,
  parameter int LW          = 5,
  parameter int PW          = 6
) (
  input  logic          clk,
  input  logic          iResetn,
  input  logic          iAbort,
  input  logic          iEnter,
  input  logic          iPressValid,
  input  logic [PW-1:0] iPressNum,
  output logic          oLoadValid,
  output logic [LW-1:0] oLoadIdx,
  output logic          oHide,
  output logic [LW-1:0] oLevel,
  output logic [2:0]    oLives,
  output logic [LW-1:0] oExpect,
  output logic [2:0]    oState,
  output logic          oWin,
  output logic          oFail,
  output logic          oCleared
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SHOW   = 3'd2;
  localparam logic [2:0] S_CHOOSE = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;
  localparam logic [2:0] S_OVER   = 3'd6;

  localparam logic [LW-1:0] START_L = LW'(START_LEVEL);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEVEL);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [2:0]    LIVES_0 = 3'(NUM_LIVES);

  logic [2:0] state;
  logic       press_live;
  logic       press_match;

  assign oState      = state;
  assign press_live  = iPressValid && (iPressNum != '0);
  assign press_match = (32'(iPressNum) == 32'(oExpect));

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state      <= S_IDLE;
      oLevel     <= START_L;
      oLives     <= LIVES_0;
      oExpect    <= ONE_L;
      oLoadIdx   <= '0;
      oLoadValid <= 1'b0;
      oHide      <= 1'b0;
      oWin       <= 1'b0;
      oFail      <= 1'b0;
      oCleared   <= 1'b0;
    end else if (iAbort) begin
      state      <= S_IDLE;
      oLevel     <= START_L;
      oLives     <= LIVES_0;
      oExpect    <= ONE_L;
      oLoadIdx   <= '0;
      oLoadValid <= 1'b0;
      oHide      <= 1'b0;
      oWin       <= 1'b0;
      oFail      <= 1'b0;
      oCleared   <= 1'b0;
    end else begin
      oWin       <= 1'b0;
      oFail      <= 1'b0;
      oLoadValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iEnter) begin
            oLevel     <= START_L;
            oLives     <= LIVES_0;
            oCleared   <= 1'b0;
            state      <= S_LOAD;
            oLoadValid <= 1'b1;
            oLoadIdx   <= ONE_L;
            oExpect    <= ONE_L;
            oHide      <= 1'b0;
          end
        end
        S_LOAD: begin
          // Index 1 was issued on entry, so the last tile ends the phase.
          if (oLoadIdx == oLevel) begin
            state    <= S_SHOW;
            oLoadIdx <= '0;
          end else begin
            oLoadIdx   <= oLoadIdx + ONE_L;
            oLoadValid <= 1'b1;
          end
        end
        S_SHOW: begin
          if (iEnter) begin
            state   <= S_CHOOSE;
            oExpect <= ONE_L;
          end
        end
        S_CHOOSE: begin
          if (press_live) begin
            if (press_match && (oExpect < oLevel)) begin
              oExpect <= oExpect + ONE_L;
              oHide   <= 1'b1;
            end else if (press_match) begin
              state <= S_WIN;
              oWin  <= 1'b1;
              oHide <= 1'b0;
            end else begin
              state <= S_FAIL;
              oFail <= 1'b1;
              oHide <= 1'b0;
              if (oLives != 3'd0) oLives <= oLives - 3'd1;
            end
          end
        end
        S_WIN: begin
          if (oLevel == MAX_L) begin
            oCleared <= 1'b1;
            state    <= S_OVER;
          end else begin
            oLevel     <= oLevel + ONE_L;
            state      <= S_LOAD;
            oLoadValid <= 1'b1;
            oLoadIdx   <= ONE_L;
            oExpect    <= ONE_L;
          end
        end
        S_FAIL: begin
          // Lives were already decremented on entry; zero means the last one is gone.
          if (oLives == 3'd0) begin
            state <= S_OVER;
          end else begin
            state      <= S_LOAD;
            oLoadValid <= 1'b1;
            oLoadIdx   <= ONE_L;
            oExpect    <= ONE_L;
          end
        end
        S_OVER: begin
          if (iEnter) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chimp_sequencer.sv
// tb/tb_chimp_sequencer.sv - table-driven bench for chimp_sequencer
// Instance a uses default parameters, instance b uses MAX_LEVEL=START_LEVEL=5.
module tb_chimp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0, enter = 1'b0, pv = 1'b0;
  logic [5:0] pn = '0;

  logic       a_lv, a_hide, a_win, a_fail, a_clr;
  logic [4:0] a_idx, a_level, a_exp;
  logic [2:0] a_lives, a_state;
  logic       b_lv, b_hide, b_win, b_fail, b_clr;
  logic [4:0] b_idx, b_level, b_exp;
  logic [2:0] b_lives, b_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  chimp_sequencer dut_a (
    .clk(clk), .iResetn(rst_n), .iAbort(abort), .iEnter(enter),
    .iPressValid(pv), .iPressNum(pn),
    .oLoadValid(a_lv), .oLoadIdx(a_idx), .oHide(a_hide), .oLevel(a_level),
    .oLives(a_lives), .oExpect(a_exp), .oState(a_state), .oWin(a_win),
    .oFail(a_fail), .oCleared(a_clr)
  );

  chimp_sequencer #(.MAX_LEVEL(5), .START_LEVEL(5)) dut_b (
    .clk(clk), .iResetn(rst_n), .iAbort(abort), .iEnter(enter),
    .iPressValid(pv), .iPressNum(pn),
    .oLoadValid(b_lv), .oLoadIdx(b_idx), .oHide(b_hide), .oLevel(b_level),
    .oLives(b_lives), .oExpect(b_exp), .oState(b_state), .oWin(b_win),
    .oFail(b_fail), .oCleared(b_clr)
  );

  typedef struct packed {
    logic       abort, enter, pv;
    logic [5:0] pn;
    logic [2:0] st;
    logic       lv;
    logic [4:0] idx;
    logic       hide;
    logic [4:0] level;
    logic [2:0] lives;
    logic [4:0] exp;
    logic       win, fail, clr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int ab, input int en, input int p, input int num,
                     input int st, input int lv, input int idx, input int hd,
                     input int lvl, input int liv, input int ex,
                     input int w, input int f, input int c);
    vec_t v;
    v.abort = ab[0]; v.enter = en[0]; v.pv = p[0]; v.pn = 6'(num);
    v.st = 3'(st); v.lv = lv[0]; v.idx = 5'(idx); v.hide = hd[0];
    v.level = 5'(lvl); v.lives = 3'(liv); v.exp = 5'(ex);
    v.win = w[0]; v.fail = f[0]; v.clr = c[0];
    vq.push_back(v);
  endtask

  // LOAD idx 1..level then SHOW; first vector carries the triggering Enter if any.
  task automatic add_load(input int first_en, input int lvl, input int liv);
    for (int i = 1; i <= lvl; i++)
      add(0, (i == 1) ? first_en : 0, 0, 0, 1, 1, i, 0, lvl, liv, 1, 0, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0, 0, lvl, liv, 1, 0, 0, 0);
  endtask

  task automatic step(input logic ab, input logic en, input logic p, input int num);
    abort = ab; enter = en; pv = p; pn = 6'(num);
    @(posedge clk);
    #1;
    abort = 1'b0; enter = 1'b0; pv = 1'b0; pn = '0;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  initial begin
    logic [25:0] act, req;

    // args: abort enter pv pn | state lv idx hide level lives exp win fail clr
    add_load(1, 4, 3);
    add(0, 0, 1, 1, 2, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, 1, 0, 0, 3, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, 0, 1, 0, 3, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, 0, 1, 1, 3, 0, 0, 1, 4, 3, 2, 0, 0, 0);
    add(0, 1, 0, 0, 3, 0, 0, 1, 4, 3, 2, 0, 0, 0);
    add(0, 0, 1, 2, 3, 0, 0, 1, 4, 3, 3, 0, 0, 0);
    add(0, 0, 1, 3, 3, 0, 0, 1, 4, 3, 4, 0, 0, 0);
    add(0, 0, 1, 4, 4, 0, 0, 0, 4, 3, 4, 1, 0, 0);
    add_load(0, 5, 3);
    add(0, 1, 0, 0, 3, 0, 0, 0, 5, 3, 1, 0, 0, 0);
    add(0, 0, 1, 1, 3, 0, 0, 1, 5, 3, 2, 0, 0, 0);
    add(0, 0, 1, 3, 5, 0, 0, 0, 5, 2, 2, 0, 1, 0);
    add_load(0, 5, 2);
    add(0, 1, 0, 0, 3, 0, 0, 0, 5, 2, 1, 0, 0, 0);
    add(0, 0, 1, 2, 5, 0, 0, 0, 5, 1, 1, 0, 1, 0);
    add_load(0, 5, 1);
    add(0, 1, 0, 0, 3, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    add(0, 0, 1, 7, 5, 0, 0, 0, 5, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0, 6, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 6, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0);
    add_load(1, 4, 3);
    add(0, 1, 0, 0, 3, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, 0, 1, 1, 3, 0, 0, 1, 4, 3, 2, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 4, 3, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 1, 0, 4, 3, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(a_state), 0);
    chk("rst_level", int'(a_level), 4);
    chk("rst_lives", int'(a_lives), 3);
    chk("rst_expect", int'(a_exp), 1);
    chk("rst_outs", int'({a_lv, a_idx, a_hide, a_win, a_fail, a_clr}), 0);
    chk("rst_b_level", int'(b_level), 5);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      abort = vq[i].abort; enter = vq[i].enter; pv = vq[i].pv; pn = vq[i].pn;
      @(posedge clk);
      #1;
      act = {a_state, a_lv, a_idx, a_hide, a_level, a_lives, a_exp, a_win, a_fail, a_clr};
      req = {vq[i].st, vq[i].lv, vq[i].idx, vq[i].hide, vq[i].level, vq[i].lives,
             vq[i].exp, vq[i].win, vq[i].fail, vq[i].clr};
      tests++;
      if (act !== req) begin
        fails++;
        $display("FAIL vec%0d: got %h expected %h", i, act, req);
      end
      abort = 1'b0; enter = 1'b0; pv = 1'b0; pn = '0;
    end

    // Asynchronous reset in the middle of a LOAD cycle.
    step(0, 0, 0, 0);
    chk("load_idx2", int'(a_idx), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(a_state), 0);
    chk("async_rst_lv", int'(a_lv), 0);
    chk("async_rst_idx", int'(a_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Instance b: clear the top level and finish the game.
    step(0, 1, 0, 0);
    chk("b_load1", int'({b_state, b_lv, b_idx}), int'({3'd1, 1'b1, 5'd1}));
    for (int i = 2; i <= 5; i++) begin
      step(0, 0, 0, 0);
      chk("b_load_idx", int'({b_state, b_lv, b_idx}), int'({3'd1, 1'b1, 5'(i)}));
    end
    step(0, 0, 0, 0);
    chk("b_show", int'(b_state), 2);
    step(0, 1, 0, 0);
    chk("b_choose", int'(b_state), 3);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, i);
    chk("b_expect5", int'({b_exp, b_hide}), int'({5'd5, 1'b1}));
    step(0, 0, 1, 5);
    chk("b_win", int'({b_state, b_win, b_hide}), int'({3'd4, 1'b1, 1'b0}));
    step(0, 0, 0, 0);
    chk("b_over", int'({b_state, b_clr, b_win, b_level}), int'({3'd6, 1'b1, 1'b0, 5'd5}));
    step(0, 0, 0, 0);
    chk("b_over_hold", int'({b_state, b_clr}), int'({3'd6, 1'b1}));
    step(0, 1, 0, 0);
    chk("b_idle", int'({b_state, b_clr}), int'({3'd0, 1'b1}));
    step(0, 1, 0, 0);
    chk("b_restart", int'({b_state, b_clr, b_level, b_lives}), int'({3'd1, 1'b0, 5'd5, 3'd3}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
